// File: rtl/idct_coef_sequencer.sv
// idct_coef_sequencer: 1-D 8-point IDCT sequencer. It loads X[0..7], then for each
// output n it issues eight (sample, select-code) pairs to an external shift-add
// multiplier, follows each product's sign through the multiplier latency,
// accumulates the products and presents the rounded, scaled x[n].
// Build option: define IDCT_SEQ_SAT_EN to saturate the output (the default wraps it).
module idct_coef_sequencer #(
  parameter int MUL_LAT = 3,
  parameter int SHIFT   = 7,
  parameter int OUT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [15:0]      in_data,
  output logic signed [15:0]      mul_data,
  output logic [6:0]              mul_ctr,
  input  logic signed [22:0]      mul_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_last
);

  localparam int ACC_W = 26;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (SHIFT - 1);
`ifdef IDCT_SEQ_SAT_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;
`endif

  typedef enum logic [1:0] {LOAD, ISSUE, DRAIN, OUT} state_t;

  state_t                   state, state_nxt;
  logic [2:0]               u_cnt, n_cnt;
  logic signed [15:0]       coef_buf [8];
  logic signed [ACC_W-1:0]  acc;
  logic [MUL_LAT-1:0]       vld_p, sgn_p;
  logic [7:0]               sel;
  logic                     issue_neg;
  logic signed [ACC_W-1:0]  prod_ext;

  // {negate, select code} for cosine term (n, u). The angle index m folds into
  // 0..16; u = 0 is the only case with m = 0 and it uses the fixed weight 45.
  function automatic logic [7:0] coef_sel(input logic [2:0] n, input logic [2:0] u);
    logic [6:0] prod;
    logic [4:0] m;
    logic [3:0] k;
    logic       neg;
    logic [6:0] code;
    prod = {3'b000, n, 1'b1} * {4'b0000, u};
    m    = prod[4:0];
    if (m > 5'd16) m = 5'd0 - m;
    neg = 1'b0;
    k   = m[3:0];
    if (m > 5'd8) begin
      neg = 1'b1;
      k   = 4'(5'd16 - m);
    end
    case (k)
      4'd0:    code = 7'b0101101;  // 45 (u = 0)
      4'd1:    code = 7'b1000000;  // 64
      4'd2:    code = 7'b0111011;  // 59
      4'd3:    code = 7'b0110101;  // 53
      4'd4:    code = 7'b0101101;  // 45
      4'd5:    code = 7'b0100100;  // 36
      4'd6:    code = 7'b0011000;  // 24
      4'd7:    code = 7'b0001100;  // 12
      default: code = 7'b0000000;  // 0
    endcase
    return {neg, code};
  endfunction

  // Round half up, arithmetic shift, then fit the value to OUT_W bits.
  function automatic logic signed [OUT_W-1:0] fmt_out(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = a + RND;
    r = r >>> SHIFT;
`ifdef IDCT_SEQ_SAT_EN
    if (r > OUT_MAX)      return OUT_MAX[OUT_W-1:0];
    else if (r < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    else                  return r[OUT_W-1:0];
`else
    return r[OUT_W-1:0];
`endif
  endfunction

  assign prod_ext = {{(ACC_W-23){mul_result[22]}}, mul_result};

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= LOAD;
    else        state <= state_nxt;
  end

  // Next-state decode and all interface outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    mul_data  = '0;
    mul_ctr   = '0;
    sel       = '0;
    issue_neg = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && u_cnt == 3'd7) state_nxt = ISSUE;
      end
      ISSUE: begin
        sel       = coef_sel(n_cnt, u_cnt);
        mul_data  = coef_buf[u_cnt];
        mul_ctr   = sel[6:0];
        issue_neg = sel[7];
        if (u_cnt == 3'd7) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (u_cnt == 3'(MUL_LAT - 1)) state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        out_data  = fmt_out(acc);
        out_last  = (n_cnt == 3'd7);
        if (out_ready) state_nxt = (n_cnt == 3'd7) ? LOAD : ISSUE;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Beat counter (load index, issue index, drain cycles) and output index.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      u_cnt <= '0;
      n_cnt <= '0;
    end else begin
      case (state)
        LOAD:    begin
                   n_cnt <= '0;
                   if (in_valid) u_cnt <= u_cnt + 3'd1;
                 end
        ISSUE:   u_cnt <= u_cnt + 3'd1;
        DRAIN:   u_cnt <= (u_cnt == 3'(MUL_LAT - 1)) ? 3'd0 : u_cnt + 3'd1;
        default: begin
                   u_cnt <= '0;
                   if (out_ready) n_cnt <= n_cnt + 3'd1;
                 end
      endcase
    end
  end

  // Coefficient buffer, written one beat at a time while loading.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 8; i++) coef_buf[i] <= '0;
    end else if (state == LOAD && in_valid) begin
      coef_buf[u_cnt] <= in_data;
    end
  end

  // Issue -> product: valid and sign ride alongside the multiplier pipeline.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_p <= '0;
      sgn_p <= '0;
    end else begin
      vld_p <= {vld_p[MUL_LAT-2:0], state == ISSUE};
      sgn_p <= {sgn_p[MUL_LAT-2:0], issue_neg};
    end
  end

  // Accumulator: cleared on ISSUE entry, adds or subtracts each returning product.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                                    acc <= '0;
    else if (state != ISSUE && state_nxt == ISSUE) acc <= '0;
    else if (vld_p[MUL_LAT-1])                     acc <= sgn_p[MUL_LAT-1] ? acc - prod_ext
                                                                           : acc + prod_ext;
  end

endmodule

// File: tb/tb_idct_coef_sequencer.sv
// Bench for idct_coef_sequencer: models the shift-add multiplier, drives rows from
// a vector table and checks outputs through a scoreboard queue.
module tb_idct_coef_sequencer;

  logic               clk = 1'b0;
  logic               rst_b = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_data = '0;
  logic signed [15:0] mul_data;
  logic [6:0]         mul_ctr;
  logic signed [22:0] mul_result;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_data;
  logic               out_last;

  int checks = 0;
  int failures = 0;
  int outs_seen = 0;

  typedef struct { int val; bit last; } exp_t;
  exp_t sb_q[$];

  typedef struct { int x[8]; int e[8]; } vec_t;
  vec_t tbl[6];

  idct_coef_sequencer #(.MUL_LAT(3), .SHIFT(7), .OUT_W(16)) dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mul_data(mul_data), .mul_ctr(mul_ctr),
    .mul_result(mul_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last));

  always #5 clk = ~clk;

  // Shift-add multiplier model: decode select-code weight, 3 register stages.
  function automatic int weight(input logic [6:0] c);
    int w;
    w = c[0] ? 1 : 0;
    if (c[2])      w += 4; else if (c[1]) w += 2;
    case (c[4:3])
      2'b01: w += 8;
      2'b10: w += 16;
      2'b11: w += 24;
      default: ;
    endcase
    if (c[6])      w += 64; else if (c[5]) w += 32;
    return w;
  endfunction

  logic signed [22:0] mp1, mp2, mp3;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mp1 <= '0; mp2 <= '0; mp3 <= '0;
    end else begin
      mp1 <= 23'(int'(mul_data) * weight(mul_ctr));
      mp2 <= mp1;
      mp3 <= mp2;
    end
  end
  assign mul_result = mp3;

  // Reference IDCT arithmetic.
  function automatic int kval(input int m);
    case (m)
      1: return 64; 2: return 59; 3: return 53; 4: return 45;
      5: return 36; 6: return 24; 7: return 12; default: return 0;
    endcase
  endfunction

  function automatic int coef(input int n, input int u);
    int m;
    if (u == 0) return 45;
    m = ((2 * n + 1) * u) % 32;
    if (m > 16) m = 32 - m;
    if (m <= 8) return kval(m);
    return -kval(16 - m);
  endfunction

  function automatic int model_out(input int acc);
    int v, q;
    v = acc + 64;
    if (v >= 0) q = v / 128;
    else        q = -((-v + 127) / 128);
`ifdef IDCT_SEQ_SAT_EN
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
`else
    q = q & 32'h0000FFFF;
    if (q >= 32768) q = q - 65536;
`endif
    return q;
  endfunction

  function automatic int model_n(input int x[8], input int n);
    int acc;
    acc = 0;
    for (int u = 0; u < 8; u++) acc += x[u] * coef(n, u);
    return model_out(acc);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Scoreboard consumer: compare each accepted output sample.
  always @(negedge clk) begin
    if (rst_b && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_data", int'(out_data), e.val);
        check("out_last", int'(out_last), int'(e.last));
      end
      outs_seen++;
    end
  end

  task automatic send_row(input int x[8], input int e[8]);
    for (int n = 0; n < 8; n++) sb_q.push_back('{val: e[n], last: (n == 7)});
    for (int u = 0; u < 8; u++) begin
      int k;
      k = 0;
      while (!in_ready && k < 400) begin
        @(posedge clk); #1; k++;
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      in_valid = 1'b1;
      in_data  = 16'(x[u]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      @(posedge clk); #1; k++;
    end
    check("drain_queue_left", sb_q.size(), 0);
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!out_valid && k < budget) begin
      @(posedge clk); #1; k++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int xs[8];
    int es[8];

    // Vector table: hand-expected rows first, then model-expected rows.
    tbl[0].x = '{128, 0, 0, 0, 0, 0, 0, 0};
    tbl[0].e = '{45, 45, 45, 45, 45, 45, 45, 45};
    tbl[1].x = '{0, 128, 0, 0, 0, 0, 0, 0};
    tbl[1].e = '{64, 53, 36, 12, -12, -36, -53, -64};
    tbl[2].x = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    tbl[3].x = '{-32768, 0, 0, 0, 0, 0, 0, 0};
    for (int r = 4; r < 6; r++)
      for (int u = 0; u < 8; u++) tbl[r].x[u] = int'($urandom_range(4000)) - 2000;
    for (int r = 2; r < 6; r++)
      for (int n = 0; n < 8; n++) tbl[r].e[n] = model_n(tbl[r].x, n);
`ifdef IDCT_SEQ_SAT_EN
    tbl[2].e[0] = 32767;
`else
    tbl[2].e[0] = 20989;
`endif

    // Reset state.
    #3;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_mul_ctr", int'(mul_ctr), 0);
    check("rst_mul_data", int'(mul_data), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    #20 rst_b = 1'b1;
    @(posedge clk); #1;

    // Table rows with out_ready held high.
    for (int r = 0; r < 6; r++) begin
      send_row(tbl[r].x, tbl[r].e);
      wait_drain(300);
    end

    // Backpressure at n = 3.
    out_ready = 1'b0;
    send_row(tbl[1].x, tbl[1].e);
    for (int n = 0; n < 8; n++) begin
      wait_valid(100);
      if (n == 3) begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check("bp_out_data", int'(out_data), tbl[1].e[3]);
          check("bp_out_valid", int'(out_valid), 1);
          check("bp_mul_ctr", int'(mul_ctr), 0);
          @(posedge clk); #1;
        end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    out_ready = 1'b1;
    wait_drain(50);

    // Input gating: in_valid held high with junk during compute.
    send_row(tbl[4].x, tbl[4].e);
    in_valid = 1'b1;
    in_data  = 16'sh5555;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      check("gate_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    in_data  = '0;
    wait_drain(300);
    @(posedge clk); #1;
    check("gate_ready_after_row", int'(in_ready), 1);

    // Reset during ISSUE of n = 2, then a fresh DC row.
    begin
      int base, k;
      base = outs_seen;
      send_row(tbl[0].x, tbl[0].e);
      k = 0;
      while (outs_seen < base + 2 && k < 300) begin
        @(posedge clk); #1; k++;
      end
      check("rst_mid_outs", outs_seen - base, 2);
      k = 0;
      while (mul_ctr == 7'd0 && k < 50) begin
        @(posedge clk); #1; k++;
      end
      check("rst_mid_in_issue", int'(mul_ctr != 7'd0), 1);
      #2 rst_b = 1'b0;
      #1;
      check("rst_mid_in_ready", int'(in_ready), 1);
      check("rst_mid_mul_ctr", int'(mul_ctr), 0);
      check("rst_mid_mul_data", int'(mul_data), 0);
      check("rst_mid_out_valid", int'(out_valid), 0);
      sb_q.delete();
      #25 rst_b = 1'b1;
      @(posedge clk); #1;
      xs = tbl[0].x;
      es = tbl[0].e;
      send_row(xs, es);
      wait_drain(300);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
